// File: rtl/axi_copy_engine.sv
// AXI copy engine: reads bursts of up to MAX_BURST 64-byte beats from cmd_src into a local
// buffer and writes them out to cmd_dst, with one burst in flight at a time.
module axi_copy_engine #(
  parameter logic [7:0] AXI_ID    = 8'h00,
  parameter int         MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_src,
  input  logic [63:0]  cmd_dst,
  input  logic [31:0]  cmd_beats,
  output logic         done,
  output logic         error,
  output logic [63:0]  araddr,
  output logic [7:0]   arid,
  output logic [3:0]   arlen,
  output logic         arvalid,
  input  logic         arready,
  input  logic [511:0] rdata,
  input  logic [7:0]   rid,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [63:0]  awaddr,
  output logic [7:0]   awid,
  output logic [3:0]   awlen,
  output logic         awvalid,
  input  logic         awready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [7:0]   bid,
  input  logic         bvalid,
  output logic         bready
);
  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]   state_q, state_d;
  logic [63:0]  src_q, src_d;
  logic [63:0]  dst_q, dst_d;
  logic [31:0]  rem_q, rem_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         error_q, error_d;
  logic         aw_done_q, aw_done_d;
  logic         w_done_q, w_done_d;
  logic [511:0] buf_q [MAX_BURST];
  logic         buf_we;
  logic [4:0]   burst_n;
  logic [3:0]   len;
  logic [63:0]  step;
  logic         last_beat;
  logic         aw_hs;
  logic         w_hs;

  // The burst size is derived from the remaining count, which only changes in B,
  // so it stays stable across AR, R, WR and B of the same burst.
  assign burst_n   = (rem_q > 32'(MAX_BURST)) ? 5'(MAX_BURST) : rem_q[4:0];
  assign len       = 4'(burst_n - 5'd1);
  assign step      = {53'd0, burst_n, 6'd0};
  assign last_beat = (cnt_q == len);
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    error_d   = error_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    buf_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          rem_d   = cmd_beats;
          cnt_d   = 4'd0;
          error_d = 1'b0;
          if (cmd_beats == 32'd0) begin
            state_d = S_FIN;
          end else if ((cmd_src[5:0] != 6'd0) || (cmd_dst[5:0] != 6'd0)) begin
            error_d = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        if (arready) begin
          cnt_d   = 4'd0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (rvalid) begin
          buf_we = 1'b1;
          if ((rid != AXI_ID) || (rlast != last_beat)) begin
            error_d = 1'b1;
          end
          if (last_beat) begin
            cnt_d   = 4'd0;
            state_d = S_WR;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_WR: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          if (last_beat) begin
            w_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        // AW and the last W may complete in either order, or together.
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && last_beat))) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = 4'd0;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (bvalid) begin
          if (bid != AXI_ID) begin
            error_d = 1'b1;
          end
          src_d   = src_q + step;
          dst_d   = dst_q + step;
          rem_d   = rem_q - {27'd0, burst_n};
          state_d = (rem_q == {27'd0, burst_n}) ? S_FIN : S_AR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_q     <= 64'd0;
      dst_q     <= 64'd0;
      rem_q     <= 32'd0;
      cnt_q     <= 4'd0;
      error_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      error_q   <= error_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Staging buffer holds only payload, so it needs no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[cnt_q[IW-1:0]] <= rdata;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_FIN);
  assign error     = error_q;
  assign araddr    = src_q;
  assign arid      = AXI_ID;
  assign arlen     = len;
  assign arvalid   = (state_q == S_AR);
  assign rready    = (state_q == S_R);
  assign awaddr    = dst_q;
  assign awid      = AXI_ID;
  assign awlen     = len;
  assign awvalid   = (state_q == S_WR) && !aw_done_q;
  assign wvalid    = (state_q == S_WR) && !w_done_q;
  assign wdata     = buf_q[cnt_q[IW-1:0]];
  assign wstrb     = '1;
  assign wlast     = wvalid && last_beat;
  assign bready    = (state_q == S_B);

endmodule

// File: tb/tb_axi_copy_engine.sv
// Bench for axi_copy_engine: a stalling AXI memory responder plus a burst/data reference model
// derived from the copy command (bursts of min(remaining, MAX_BURST) beats, forward order).
module tb_axi_copy_engine;
  localparam int MAX_BURST = 16;
  localparam int LIMIT     = 20000;

  typedef struct {
    logic [63:0] addr;
    int          n;
    int          off;
  } burst_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  cmd_src;
  logic [63:0]  cmd_dst;
  logic [31:0]  cmd_beats;
  logic         done;
  logic         error;
  logic [63:0]  araddr;
  logic [7:0]   arid;
  logic [3:0]   arlen;
  logic         arvalid;
  logic         arready;
  logic [511:0] rdata;
  logic [7:0]   rid;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [63:0]  awaddr;
  logic [7:0]   awid;
  logic [3:0]   awlen;
  logic         awvalid;
  logic         awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [7:0]   bid;
  logic         bvalid;
  logic         bready;

  int total = 0;
  int bad   = 0;

  bit [511:0]   mem [bit [63:0]];
  logic [511:0] srcBeats[$];
  burst_t       expAr[$];
  burst_t       expAw[$];
  burst_t       expW[$];
  burst_t       rq[$];
  logic [511:0] wBuf[$];

  int          rBeat, rGlobal, wBeat, bN;
  logic [63:0] bAddr;
  bit          rPend, bPend, awGot, wDone, awHs, wLastHs;
  int          doneCount, arCount, awCount;
  bit          awFirstSeen, wFirstSeen;
  int          arStall, rStall, awStall, wStall, bStall;
  int          injRidBeat;
  bit          injEarly, injBid;

  axi_copy_engine #(.AXI_ID(8'h00), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_beats(cmd_beats), .done(done), .error(error),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit chance(input int stall);
    return int'($urandom_range(99)) >= stall;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] memRead(input logic [63:0] k);
    return mem.exists(k) ? mem[k] : '0;
  endfunction

  task automatic setStalls(input int ar, input int r, input int aw, input int w, input int b);
    arStall = ar; rStall = r; awStall = aw; wStall = w; bStall = b;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    expAr.delete(); expAw.delete(); expW.delete();
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Memory responder: decides each handshake at the negedge before the edge that takes it.
  initial begin
    arready = 0; rvalid = 0; rdata = '0; rid = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rq.delete(); wBuf.delete();
        rBeat = 0; wBeat = 0; rPend = 0; bPend = 0; awGot = 0; wDone = 0;
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
      end else begin
        if (done) doneCount++;

        if (rq.size() > 0 && (rPend || chance(rStall))) begin
          rvalid = 1'b1;
          rdata  = memRead((rq[0].addr >> 6) + 64'(rBeat));
          rid    = (rGlobal == injRidBeat) ? 8'h05 : 8'h00;
          rlast  = (rBeat == rq[0].n - 1) || (injEarly && rGlobal == 0);
          if (rready) begin
            rPend = 1'b0;
            rBeat++;
            rGlobal++;
            if (rBeat == rq[0].n) begin
              void'(rq.pop_front());
              rBeat = 0;
            end
          end else begin
            rPend = 1'b1;
          end
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end

        arready = 1'b0;
        if (arvalid) begin
          if (expAr.size() == 0) checkOutput("ar_unexpected", 1, 0);
          else begin
            checkOutput("araddr", araddr, expAr[0].addr);
            checkOutput("arlen", arlen, expAr[0].n - 1);
            checkOutput("arid", arid, 0);
            if (chance(arStall)) begin
              arready = 1'b1;
              rq.push_back(expAr[0]);
              void'(expAr.pop_front());
              arCount++;
            end
          end
        end

        awready = 1'b0;
        awHs    = 1'b0;
        if (awvalid) begin
          if (expAw.size() == 0) checkOutput("aw_unexpected", 1, 0);
          else begin
            checkOutput("awaddr", awaddr, expAw[0].addr);
            checkOutput("awlen", awlen, expAw[0].n - 1);
            checkOutput("awid", awid, 0);
            if (chance(awStall)) begin
              awready = 1'b1;
              awHs    = 1'b1;
              bAddr   = expAw[0].addr;
              bN      = expAw[0].n;
              void'(expAw.pop_front());
              awCount++;
            end
          end
        end

        wready  = 1'b0;
        wLastHs = 1'b0;
        if (wvalid) begin
          if (expW.size() == 0) checkOutput("w_unexpected", 1, 0);
          else begin
            checkOutput("wdata", wdata, srcBeats[expW[0].off + wBeat]);
            checkOutput("wlast", wlast, wBeat == expW[0].n - 1);
            checkOutput("wstrb", wstrb, {64{1'b1}});
            if (chance(wStall)) begin
              wready = 1'b1;
              wBuf.push_back(wdata);
              wBeat++;
              if (wBeat == expW[0].n) wLastHs = 1'b1;
            end
          end
        end
        if (awHs && !wDone && !wLastHs) awFirstSeen = 1'b1;
        if (wLastHs && !awGot && !awHs) wFirstSeen = 1'b1;
        if (awHs) awGot = 1'b1;
        if (wLastHs) wDone = 1'b1;

        if (awGot && wDone && (bPend || chance(bStall))) begin
          bvalid = 1'b1;
          bid    = injBid ? 8'h05 : 8'h00;
          if (bready) begin
            checkOutput("w_beats", wBuf.size(), bN);
            foreach (wBuf[i]) mem[(bAddr >> 6) + 64'(i)] = wBuf[i];
            wBuf.delete();
            awGot = 1'b0; wDone = 1'b0; wBeat = 0; bPend = 1'b0;
            void'(expW.pop_front());
          end else begin
            bPend = 1'b1;
          end
        end else begin
          bvalid = 1'b0;
        end
      end
    end
  end

  // Fills source memory and the expected burst lists; returns the expected burst count.
  task automatic prepCmd(input logic [63:0] src, input logic [63:0] dst, input int beats,
                         output int nb);
    int n;
    srcBeats.delete(); expAr.delete(); expAw.delete(); expW.delete();
    for (int i = 0; i < beats; i++) begin
      srcBeats.push_back(rand512());
      mem[(src >> 6) + 64'(i)] = srcBeats[i];
    end
    nb = 0;
    if (src[5:0] == 6'd0 && dst[5:0] == 6'd0) begin
      for (int off = 0; off < beats; off += n) begin
        n = (beats - off > MAX_BURST) ? MAX_BURST : beats - off;
        expAr.push_back('{src + 64'(off) * 64, n, off});
        expAw.push_back('{dst + 64'(off) * 64, n, off});
        expW.push_back('{dst + 64'(off) * 64, n, off});
        nb++;
      end
    end
    doneCount = 0; arCount = 0; awCount = 0; rGlobal = 0;
  endtask

  task automatic applyStimulus(input logic [63:0] src, input logic [63:0] dst, input int beats,
                               input bit expErr, input string name);
    int nb, cycles;
    bit badAlign;
    badAlign = (src[5:0] != 6'd0) || (dst[5:0] != 6'd0);
    prepCmd(src, dst, beats, nb);
    @(negedge clk);
    checkOutput({name, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_beats = beats;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput({name, "_err_accept"}, error, (beats != 0) && badAlign);
    cycles = 1;
    while (!done && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) begin
      checkOutput({name, "_timeout"}, 0, 1);
      doReset();
    end else begin
      checkOutput({name, "_err_done"}, error, expErr);
      if (beats == 0 || badAlign) checkOutput({name, "_done_latency"}, cycles <= 2, 1);
      repeat (3) @(negedge clk);
      checkOutput({name, "_done_count"}, doneCount, 1);
      checkOutput({name, "_ar_count"}, arCount, nb);
      checkOutput({name, "_aw_count"}, awCount, nb);
      if (!badAlign)
        for (int i = 0; i < beats; i++)
          checkOutput({name, "_mem"}, memRead((dst >> 6) + 64'(i)), srcBeats[i]);
    end
  endtask

  initial begin
    int nb, cycles;
    reset = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_beats = '0;
    injRidBeat = -1; injEarly = 1'b0; injBid = 1'b0;
    awFirstSeen = 1'b0; wFirstSeen = 1'b0;
    setStalls(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    checkOutput("rst_done_error", {done, error}, 0);
    checkOutput("rst_araddr", araddr, 0);
    reset = 1'b0;

    applyStimulus(64'h1000, 64'h8000, 1, 0, "single");
    applyStimulus(64'h1000, 64'h10000, 40, 0, "b40");
    applyStimulus(64'h2000, 64'h20000, 0, 0, "zero");
    applyStimulus(64'h1010, 64'h30000, 3, 1, "misalign");
    applyStimulus(64'h3000, 64'h30000, 2, 0, "clear");

    setStalls(90, 90, 30, 30, 30);
    for (int t = 0; t < 4; t++)
      applyStimulus(64'h100000 + 64'($urandom_range(4095)) * 64,
                    64'h200000 + 64'($urandom_range(4095)) * 64,
                    int'($urandom_range(1, 40)), 0, "rand");

    setStalls(0, 0, 0, 0, 0);
    applyStimulus(64'h4000, 64'h40000, 4, 0, "aw_first");
    setStalls(0, 0, 97, 0, 0);
    applyStimulus(64'h5000, 64'h50000, 2, 0, "w_first");

    setStalls(20, 20, 20, 20, 20);
    injRidBeat = 3;
    applyStimulus(64'h6000, 64'h60000, 8, 1, "bad_rid");
    injRidBeat = -1;
    injEarly = 1'b1;
    applyStimulus(64'h7000, 64'h70000, 4, 1, "early_rlast");
    injEarly = 1'b0;
    injBid = 1'b1;
    applyStimulus(64'h9000, 64'h90000, 2, 1, "bad_bid");
    injBid = 1'b0;

    setStalls(0, 90, 0, 0, 0);
    prepCmd(64'hA000, 64'hA0000, 16, nb);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_src = 64'hA000; cmd_dst = 64'hA0000; cmd_beats = 16;
    @(negedge clk);
    cmd_valid = 1'b0;
    cycles = 0;
    while (!rready && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("rst_mid_reach_r", rready, 1);
    doReset();
    checkOutput("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    checkOutput("rst_mid_cmd_ready", cmd_ready, 1);
    checkOutput("rst_mid_no_done", doneCount, 0);

    setStalls(30, 30, 30, 30, 30);
    applyStimulus(64'hB000, 64'hB0000, 20, 0, "recover");

    checkOutput("order_aw_first", awFirstSeen, 1);
    checkOutput("order_w_first", wFirstSeen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
